// File: rtl/mem_fifo_loader_if.sv
// mem_fifo_loader_if
//   Bus bundle between the loader and its memory / FIFO neighbours.
//   master : loader side (drives the read request and the FIFO write port)
//   slave  : memory + FIFO side
//   mem_address       word address of the outstanding read
//   mem_read          read request, held until accepted
//   mem_waitrequest   slave not accepting the request this cycle
//   mem_readdata      returned word (ROWS bytes)
//   mem_readdatavalid mem_readdata valid this cycle
//   fifo_wdata        byte shared by all FIFO write ports
//   fifo_a_wren       one-hot write enable, bit i selects A FIFO i
//   fifo_b_wren       write enable for the B FIFO
//   fifo_a_full       per-row A FIFO full
//   fifo_b_full       B FIFO full
interface mem_fifo_loader_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ROWS       = 8,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]      mem_address;
   logic                       mem_read;
   logic                       mem_waitrequest;
   logic [DATA_WIDTH*ROWS-1:0] mem_readdata;
   logic                       mem_readdatavalid;
   logic [DATA_WIDTH-1:0]      fifo_wdata;
   logic [ROWS-1:0]            fifo_a_wren;
   logic                       fifo_b_wren;
   logic [ROWS-1:0]            fifo_a_full;
   logic                       fifo_b_full;

   modport master (
      output mem_address, mem_read, fifo_wdata, fifo_a_wren, fifo_b_wren,
      input  mem_waitrequest, mem_readdata, mem_readdatavalid, fifo_a_full, fifo_b_full
   );

   modport slave (
      input  mem_address, mem_read, fifo_wdata, fifo_a_wren, fifo_b_wren,
      output mem_waitrequest, mem_readdata, mem_readdatavalid, fifo_a_full, fifo_b_full
   );
endinterface

// File: rtl/mem_fifo_loader.sv
// mem_fifo_loader
//   Upstream feeder for the ROWS-row matrix-vector MAC array. On start it
//   reads ROWS A-matrix words and one B-vector word (one outstanding read at a
//   time), unpacks each word most-significant byte first and pushes the bytes
//   into A FIFO <row> or the B FIFO, then raises a sticky done.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : level, sampled in IDLE; a rising edge in DONE restarts
//   done       : all bytes loaded (sticky)
//   bus        : memory read master + FIFO write port (master modport)
module mem_fifo_loader #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           ROWS       = 8,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              done,
   mem_fifo_loader_if.master bus
);
   localparam int unsigned NF     = ROWS + 1;
   localparam int unsigned IDX_W  = $clog2(ROWS + 1);
   localparam int unsigned WORD_W = DATA_WIDTH * ROWS;

   typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, UNPACK, DONE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  word_idx;
   logic [IDX_W-1:0]  byte_cnt;
   logic [WORD_W-1:0] shreg;
   logic              start_q;
   logic [NF-1:0]     full_vec;
   logic [NF-1:0]     sel_vec;
   logic              wr_en;

   // Index ROWS of the combined vectors is the B FIFO.
   assign full_vec = {bus.fifo_b_full, bus.fifo_a_full};
   assign sel_vec  = NF'(1) << word_idx;

   // Write decision uses the target's full flag in the same cycle so a
   // full FIFO stalls without losing or duplicating a byte.
   assign wr_en           = (state == UNPACK) && !full_vec[word_idx];
   assign bus.fifo_a_wren = wr_en ? sel_vec[ROWS-1:0] : '0;
   assign bus.fifo_b_wren = wr_en & sel_vec[ROWS];
   assign bus.fifo_wdata  = shreg[WORD_W-1 -: DATA_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         done            <= 1'b0;
         bus.mem_read    <= 1'b0;
         bus.mem_address <= '0;
         word_idx        <= '0;
         byte_cnt        <= '0;
         shreg           <= '0;
         start_q         <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (start) begin
                  word_idx        <= '0;
                  bus.mem_read    <= 1'b1;
                  bus.mem_address <= BASE_ADDR;
                  state           <= REQ;
               end
            end
            REQ: begin
               if (!bus.mem_waitrequest) begin
                  bus.mem_read <= 1'b0;
                  state        <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (bus.mem_readdatavalid) begin
                  shreg    <= bus.mem_readdata;
                  byte_cnt <= '0;
                  state    <= UNPACK;
               end
            end
            UNPACK: begin
               if (wr_en) begin
                  shreg    <= shreg << DATA_WIDTH;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == IDX_W'(ROWS - 1)) begin
                     if (word_idx != IDX_W'(ROWS)) begin
                        word_idx        <= word_idx + 1'b1;
                        bus.mem_read    <= 1'b1;
                        bus.mem_address <= BASE_ADDR + ADDR_WIDTH'(word_idx + 1'b1);
                        state           <= REQ;
                     end else begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               // Restart only on a fresh rising edge of start.
               if (start && !start_q) begin
                  done            <= 1'b0;
                  word_idx        <= '0;
                  bus.mem_read    <= 1'b1;
                  bus.mem_address <= BASE_ADDR;
                  state           <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_fifo_loader.sv
// tb_mem_fifo_loader
//   Scoreboard bench for mem_fifo_loader. The memory/FIFO environment pushes
//   the expected byte stream whenever it returns a word; a separate monitor
//   pops and compares on every FIFO write. Done timing is predicted from the
//   nominal 91 cycles plus injected wait, latency and stall cycles.
module tb_mem_fifo_loader;
   localparam int unsigned DW = 8;
   localparam int unsigned RW = 8;
   localparam int unsigned AW = 32;

   typedef struct packed {
      logic [3:0] fifo;
      logic [7:0] data;
   } wr_t;

   logic clk;
   logic rst_n;
   logic start;
   logic done;

   mem_fifo_loader_if #(.DATA_WIDTH(DW), .ROWS(RW), .ADDR_WIDTH(AW)) bus ();

   mem_fifo_loader #(
      .DATA_WIDTH(DW),
      .ROWS      (RW),
      .ADDR_WIDTH(AW),
      .BASE_ADDR (32'd0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .done (done),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned ecount = 0;
   always @(posedge clk) ecount++;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] mem_words [9];
   wr_t         expq[$];
   logic [31:0] addrq[$];
   int          wr_cnt [9];

   // environment configuration
   int wait_addr = -1;
   int wait_n    = 0;
   int lat       = 1;
   bit rand_mode = 0;
   bit bp_arm    = 0;

   // environment statistics / state
   int          waits, extra_lat, stalls, hold_wait;
   int          tgt_now = -1;
   bit          stall_now = 0;
   bit          pending = 0;
   bit          req_active = 0;
   logic [31:0] req_addr;
   int          hold, wait_left, bp_left, acc_addr, lw;
   int unsigned valid_at, acc_e;
   logic [8:0]  fv;
   logic [8:0]  wr;
   wr_t         e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory slave and FIFO-full driver.
   initial begin : env
      bus.mem_waitrequest   = 1'b0;
      bus.mem_readdatavalid = 1'b0;
      bus.mem_readdata      = '0;
      bus.fifo_a_full       = '0;
      bus.fifo_b_full       = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expq.delete();
            addrq.delete();
            pending    = 0;
            req_active = 0;
            bp_left    = 0;
            stall_now  = 0;
            tgt_now    = -1;
            bus.mem_waitrequest   = 1'b0;
            bus.mem_readdatavalid = 1'b0;
            bus.fifo_a_full       = '0;
            bus.fifo_b_full       = 1'b0;
         end else begin
            fv = rand_mode ? (9'($urandom) & 9'($urandom)) : 9'd0;
            if (bp_arm && wr_cnt[2] == 4) begin
               bp_left = 5;
               bp_arm  = 0;
            end
            if (bp_left > 0) begin
               fv[2] = 1'b1;
               bp_left--;
            end
            bus.fifo_a_full = fv[7:0];
            bus.fifo_b_full = fv[8];
            tgt_now   = (expq.size() > 0) ? int'(expq[0].fifo) : -1;
            stall_now = (tgt_now >= 0) && fv[tgt_now];
            if (stall_now) stalls++;

            bus.mem_readdatavalid = 1'b0;
            bus.mem_readdata      = {$urandom, $urandom};
            if (pending && ecount == valid_at) begin
               bus.mem_readdatavalid = 1'b1;
               bus.mem_readdata      = mem_words[acc_addr];
               for (int c = 0; c < 8; c++)
                  expq.push_back(wr_t'{fifo: 4'(acc_addr), data: mem_words[acc_addr][63-8*c -: 8]});
               pending = 0;
            end else if (!pending && rand_mode && $urandom_range(0, 7) == 0) begin
               bus.mem_readdatavalid = 1'b1;
            end

            bus.mem_waitrequest = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (bus.mem_read) begin
               if (!req_active) begin
                  req_active = 1;
                  req_addr   = bus.mem_address;
                  hold       = 0;
                  wait_left  = (int'(bus.mem_address) == wait_addr) ? wait_n :
                               (rand_mode ? int'($urandom_range(0, 2)) : 0);
               end else begin
                  chk("addr_held", bus.mem_address, req_addr);
               end
               hold++;
               if (wait_left > 0) begin
                  bus.mem_waitrequest = 1'b1;
                  wait_left--;
                  waits++;
               end else begin
                  bus.mem_waitrequest = 1'b0;
                  if (addrq.size() > 0) chk("req_addr", bus.mem_address, addrq.pop_front());
                  else                  chk("extra_req", bus.mem_address, 64'hffff_ffff_ffff_ffff);
                  if (int'(bus.mem_address) == wait_addr) hold_wait = hold;
                  lw = rand_mode ? int'($urandom_range(1, 4)) : lat;
                  extra_lat += lw - 1;
                  valid_at   = ecount + lw;
                  acc_e      = ecount;
                  acc_addr   = (bus.mem_address < 9) ? int'(bus.mem_address) : 0;
                  pending    = 1;
                  req_active = 0;
               end
            end
         end
      end
   end

   // FIFO write monitor: pops the expected stream on every write.
   initial begin : monitor
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            wr = {bus.fifo_b_wren, bus.fifo_a_wren};
            if (wr != '0) begin
               chk("wren_onehot", $countones(wr), 1);
               if (expq.size() == 0) begin
                  chk("unexpected_write", wr, 0);
               end else begin
                  e = expq.pop_front();
                  chk("wr_target", wr, 9'(1) << e.fifo);
                  chk("wr_data", bus.fifo_wdata, e.data);
                  wr_cnt[e.fifo]++;
               end
            end
            if (stall_now) begin
               chk("stall_no_wren", wr, 0);
               if (expq.size() > 0) chk("stall_wdata", bus.fifo_wdata, expq[0].data);
            end
         end
      end
   end

   task automatic start_fetch();
      for (int i = 0; i < 9; i++) begin
         addrq.push_back(32'(i));
         wr_cnt[i] = 0;
      end
      waits = 0; extra_lat = 0; stalls = 0; hold_wait = -1;
      @(negedge clk); #2;
      start = 1'b1;
      @(negedge clk); #2;
      start = 1'b0;
   endtask

   // exp_done < 0 : predict from injected wait/latency/stall cycles.
   task automatic run(input int exp_done, input bit busy_pulse);
      int unsigned base;
      bit got, pulsed;
      int total, expc;
      for (int i = 0; i < 9; i++) begin
         addrq.push_back(32'(i));
         wr_cnt[i] = 0;
      end
      waits = 0; extra_lat = 0; stalls = 0; hold_wait = -1;
      @(negedge clk); #2;
      start = 1'b1;
      base  = ecount;
      @(negedge clk); #2;
      start = 1'b0;
      chk("c1_mem_read", bus.mem_read, 1);
      chk("c1_addr", bus.mem_address, 0);
      chk("c1_done", done, 0);
      got = 0; pulsed = 0;
      for (int n = 0; n < 3000 && !got; n++) begin
         if (done) got = 1;
         else begin
            if (busy_pulse && !pulsed && wr_cnt[4] == 2) begin
               start  = 1'b1;
               pulsed = 1;
            end else if (start) begin
               start = 1'b0;
            end
            @(negedge clk); #2;
         end
      end
      start = 1'b0;
      expc = (exp_done < 0) ? 91 + waits + extra_lat + stalls : exp_done;
      chk("done_seen", got, 1);
      chk("done_cycle", ecount - base, expc);
      chk("sb_drained", expq.size(), 0);
      chk("addr_drained", addrq.size(), 0);
      total = 0;
      for (int i = 0; i < 9; i++) total += wr_cnt[i];
      chk("bytes_written", total, 72);
      repeat (3) @(negedge clk);
      #2;
      chk("done_sticky", done, 1);
   endtask

   task automatic async_reset(input string tag);
      #1 rst_n = 1'b0;
      #1;
      chk({tag, "_mem_read"}, bus.mem_read, 0);
      chk({tag, "_addr"}, bus.mem_address, 0);
      chk({tag, "_a_wren"}, bus.fifo_a_wren, 0);
      chk({tag, "_b_wren"}, bus.fifo_b_wren, 0);
      chk({tag, "_wdata"}, bus.fifo_wdata, 0);
      chk({tag, "_done"}, done, 0);
      @(negedge clk);
      @(negedge clk); #2;
      rst_n = 1'b1;
   endtask

   initial begin : main
      bit hit;
      rst_n = 1'b0;
      start = 1'b0;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 8; c++)
            mem_words[r][63-8*c -: 8] = 8'((r << 4) | (c + 1));
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk); #2;
      chk("rst_done", done, 0);
      chk("rst_mem_read", bus.mem_read, 0);
      chk("rst_addr", bus.mem_address, 0);
      chk("rst_wdata", bus.fifo_wdata, 0);
      chk("rst_wren", {bus.fifo_b_wren, bus.fifo_a_wren}, 0);

      run(91, 0);                               // nominal

      wait_addr = 3; wait_n = 3;                // waitrequest on row 3
      run(94, 0);
      chk("wait_hold_cycles", hold_wait, 4);
      wait_addr = -1; wait_n = 0;

      bp_arm = 1;                               // A FIFO 2 full for 5 cycles
      run(96, 0);
      bp_arm = 0;

      run(91, 1);                               // start pulse while busy
      run(91, 0);                               // restart from DONE

      async_reset("rst_in_done");

      lat = 3;                                  // reset during WAIT_DATA of row 5
      start_fetch();
      hit = 0;
      for (int n = 0; n < 500 && !hit; n++) begin
         if (pending && acc_addr == 5 && ecount == acc_e + 1) hit = 1;
         else begin @(negedge clk); #2; end
      end
      chk("reach_wait_row5", hit, 1);
      async_reset("rst_in_wait");
      lat = 1;
      run(91, 0);

      start_fetch();                            // reset while writing row 3
      hit = 0;
      for (int n = 0; n < 500 && !hit; n++) begin
         if (wr_cnt[3] == 3) hit = 1;
         else begin @(negedge clk); #2; end
      end
      chk("reach_unpack_row3", hit, 1);
      chk("pre_rst_wren", bus.fifo_a_wren, 8'h08);
      async_reset("rst_in_unpack");

      wait_addr = 6; wait_n = 1000;             // reset while request is held
      start_fetch();
      hit = 0;
      for (int n = 0; n < 500 && !hit; n++) begin
         if (req_active && req_addr == 6) hit = 1;
         else begin @(negedge clk); #2; end
      end
      chk("reach_req_row6", hit, 1);
      chk("pre_rst_mem_read", bus.mem_read, 1);
      async_reset("rst_in_req");
      wait_addr = -1; wait_n = 0;

      lat = 4;                                  // slow read latency
      run(118, 0);
      lat = 1;

      rand_mode = 1;                            // randomized traffic
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < 9; r++) mem_words[r] = {$urandom, $urandom};
         run(-1, 0);
      end
      rand_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_fifo_loader.md
Name: mem_fifo_loader

Overview:
- Upstream feeder for the 8-row matrix-vector MAC array.
- On `start`, fetches eight 64-bit A-matrix rows and one 64-bit B-vector word from an Avalon-MM-style read master interface.
- Unpacks each word into bytes and pushes them into the per-row A FIFOs and the shared B FIFO.
- Raises `done` when all 72 bytes are loaded, so the MAC array can begin.

Parameters:
- DATA_WIDTH, 8, byte width written to FIFOs.
- ROWS, 8, number of A rows and A FIFOs; also bytes per memory word.
- ADDR_WIDTH, 32, memory address width.
- BASE_ADDR, 0, word address of A row 0. Row i is at BASE_ADDR+i; B is at BASE_ADDR+ROWS.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE.
- done  out  1  all bytes loaded; sticky.
- mem_address  out  ADDR_WIDTH  word address.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  slave not accepting request.
- mem_readdata  in  DATA_WIDTH*ROWS  returned word.
- mem_readdatavalid  in  1  mem_readdata valid this cycle.
- fifo_wdata  out  DATA_WIDTH  byte shared by all FIFOs.
- fifo_a_wren  out  ROWS  one-hot write enable, bit i selects A FIFO i.
- fifo_b_wren  out  1  write enable for B FIFO.
- fifo_a_full  in  ROWS  per-row A FIFO full.
- fifo_b_full  in  1  B FIFO full.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; done=0; mem_read=0; mem_address=0; fifo_wdata=0; fifo_a_wren=0; fifo_b_wren=0; word index=0; byte count=0.
- States: IDLE, REQ, WAIT_DATA, UNPACK, DONE.
- IDLE:
  - On start=1 at a clock edge: word index=0, go to REQ.
- REQ:
  - mem_read=1; mem_address=BASE_ADDR+word index.
  - Both are held stable while mem_waitrequest=1.
  - On a cycle with mem_waitrequest=0 the request is accepted: go to WAIT_DATA.
  - mem_read=0 from the next cycle onward.
- WAIT_DATA:
  - mem_read=0.
  - On mem_readdatavalid=1: capture mem_readdata into a shift register, byte count=0, go to UNPACK.
  - mem_readdatavalid arriving outside WAIT_DATA is ignored.
- UNPACK:
  - One byte per cycle, most-significant byte first. Bits [63:56] are column 0; bits [7:0] are column 7.
  - Target is A FIFO (word index) for index 0..ROWS-1, and the B FIFO for index ROWS.
  - A write occurs in a cycle iff the target FIFO's full=0. That cycle: the wren bit is high, fifo_wdata holds the byte, the shift register advances, byte count increments.
  - If the target is full: wren=0, fifo_wdata is held, no advance (stall, no byte dropped).
  - After the 8th write:
    - If word index<ROWS: increment word index, go to REQ.
    - Else: go to DONE.
- Write-enable rules: at most one of fifo_a_wren/fifo_b_wren is high in any cycle. All wren are 0 outside UNPACK.
- DONE:
  - done=1.
  - Stays until start is seen low and then high again (rising edge detected in DONE). That edge clears done and restarts at word 0 (REQ next cycle).
- Start handling: start toggling in REQ/WAIT_DATA/UNPACK is ignored.
- Latency (zero wait states, readdatavalid one cycle after accept, FIFOs never full):
  - Each word takes 10 cycles: 1 REQ, 1 WAIT_DATA, 8 UNPACK.
  - start sampled at edge 0 → first mem_read in cycle 1 → done=1 in cycle 91.
- Wait states: each cycle of mem_waitrequest, each extra cycle of read latency, and each full-stall cycle adds exactly one cycle.
- Reset mid-operation: all outputs return to reset values immediately. A partial FIFO fill is not undone; FIFO flushing is the owner's responsibility.
- Outstanding reads: exactly one at a time; no pipelined reads.

Test Plan:
- Nominal load:
  - Stimulus: memory row i = 64'h{i,1..8 pattern}, e.g. row0=64'h0102030405060708, row7=64'h7172737475767778, B=64'h8182838485868788; no wait states.
  - Required: A FIFO0 receives 01..08 in order, A FIFO7 receives 71..78, B FIFO receives 81..88; addresses 0..8 issued once each; done=1 in cycle 91; wren one-hot every write cycle.
- waitrequest stall:
  - Stimulus: hold mem_waitrequest=1 for 3 cycles on the row-3 request.
  - Required: mem_read=1 and mem_address=3 held constant for 4 cycles; done arrives at cycle 94; data unchanged.
- FIFO backpressure:
  - Stimulus: assert fifo_a_full[2]=1 for 5 cycles after the 4th byte of row 2.
  - Required: no wren during the stall; fifo_wdata holds 8'h25; bytes 25..28 written afterward with none lost or duplicated; done at cycle 96.
- Start while busy and restart:
  - Stimulus: pulse start during UNPACK of row 4.
  - Required: no effect, done at 91.
  - Stimulus: then drop start and raise it again.
  - Required: done clears, mem_read with address 0 in the next cycle, full reload repeats.
- Reset mid-operation:
  - Stimulus: rst_n=0 asynchronously during WAIT_DATA of row 5.
  - Required: mem_read, all wren, and done go 0 without waiting for a clock edge.
  - Stimulus: start after release.
  - Required: fetch begins at address 0.
- Slow read latency:
  - Stimulus: mem_readdatavalid returned 4 cycles after accept for every word.
  - Required: done at cycle 91+9×3=118; byte order correct.
